alu4_share_ctrl: RTL and testbench
==================================

Name: alu4_share_ctrl

Overview:
- Sequencing and arbitration controller that shares one 4-bit ALU datapath between two requesters.
- Accepts operations over valid/ready request channels and arbitrates round-robin.
- Registers the ALU result and flags, and returns them on one tagged response channel.
- Sits between two client blocks (for example, a microsequencer and a test port) and the combinational ALU slice.

Parameters:
- CNT_W, 8, width of the per-requester grant counters (wrap-around).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation accepted this cycle.
- req0_a, req0_b  input  4 each  requester 0 operands.
- req0_op  input  3  requester 0 opcode.
- req1_a, req1_b  input  4 each  requester 1 operands.
- req1_op  input  3  requester 1 opcode.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that owns the response.
- rsp_result  output  4  ALU result.
- rsp_zero  output  1  zero flag.
- rsp_over  output  1  overflow flag.
- rsp_cout  output  1  carry-out flag.
- busy  output  1  high in any state other than IDLE.
- grant_cnt0, grant_cnt1  output  CNT_W each  accepted-operation counts.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - All rsp_* = 0, req_ready = 0, busy = 0, grant counters = 0.
  - Reset asserted in any state abandons the in-flight operation immediately.
  - rsp_valid falls asynchronously; no partial response is ever presented.
- Opcodes. Sub = a + ~b + 1, where cout=1 means no borrow.
  - 000 add: result = a+b.
  - 001 sub: result = a-b.
  - 010: result = ~a.
  - 011: result = a&b.
  - 100: result = a|b.
  - 101: result = a^b.
  - 110 slt: result = 0001 if a<b signed, else 0000; less = sub[3]^sub_over.
  - 111 eq: result = 0001 if a==b, else 0000.
- Flags:
  - add/sub: cout = bit 4 of the 5-bit sum; over = (a[3]==xb[3]) && (sum[3]!=a[3]), where xb is the second operand after inversion (~b for sub/slt/eq, b for add).
  - 110/111: cout/over come from the internal subtraction.
  - 010-101: cout = over = 0.
  - zero = (result==0) for every opcode.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = one-hot grant, combinational from req_valid and rr_ptr.
  - If both valid, grant the rr_ptr side; if one valid, grant it.
  - On handshake: latch a, b, op and id; increment grant_cnt[id] (wraps at 2^CNT_W); go to EXEC.
- EXEC: ALU computes from the latched operands; register result, flags and id into rsp_*; rsp_valid <= 1; go to RESP. req_ready = 0.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, rr_ptr <= ~rsp_id, go to IDLE. req_ready = 0.
- Timing:
  - Latency: request handshake in cycle N, rsp_valid high in cycle N+2.
  - Minimum initiation interval is 3 cycles with rsp_ready held high.
- Requester rules:
  - A requester keeps valid and operands stable until ready.
  - Deasserting valid before grant is allowed; the controller never latches an ungranted request.
- Values:
  - rsp_result/flags keep their last value after the handshake.
  - Only rsp_valid qualifies them.
- Opcode handling: unused opcode encodings do not exist, since all 8 are defined.

Decomposition:
- Shared package alu4_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_EQ.
  - FSM state encoding: S_IDLE, S_EXEC, S_RESP.
  - data width constant DW=4.
- One sub-module, alu4_core: purely combinational, (a, b, op) -> (result, zero, over, cout).
- The controller instantiates alu4_core once.

Test Plan:
- Requester 0 sends add a=0111, b=0001, rsp_ready=1 -> rsp_valid 2 cycles after handshake, result=1000, over=1, cout=0, zero=0, rsp_id=0.
- Requester 1 sends sub a=0011, b=0011 -> result=0000, zero=1, cout=1, over=0, rsp_id=1.
- slt a=1000, b=0001 -> result=0001, over=1, cout=1. Repeat with a=0001, b=1000 -> result=0000.
- Both req_valid held high from reset with rsp_ready=1 -> grants alternate 0,1,0,1. After 4 ops, grant_cnt0=2 and grant_cnt1=2.
- rsp_ready low for 5 cycles in RESP -> rsp_* stable, req_ready=00, busy=1. Raise rsp_ready -> IDLE next cycle.
- rst_n pulsed low during EXEC -> rsp_valid=0 and state IDLE immediately. The abandoned op produces no response; counters read 0.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the shared 4-bit ALU controller:
// opcode encodings, controller FSM states and the datapath width.
package alu4_pkg;

  localparam int DW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU slice: one shared adder serves add, sub, slt and eq,
// so slt/eq report the carry and overflow of their internal subtraction.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          over,
  output logic          cout
);

  logic [DW-1:0] xb;
  logic [DW:0]   sum;
  logic          arith_over;

  always_comb begin
    xb         = (op == OP_ADD) ? b : ~b;
    sum        = {1'b0, a} + {1'b0, xb} + {{DW{1'b0}}, (op != OP_ADD)};
    arith_over = (a[DW-1] == xb[DW-1]) && (sum[DW-1] != a[DW-1]);

    result = '0;
    over   = 1'b0;
    cout   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        result = sum[DW-1:0];
        over   = arith_over;
        cout   = sum[DW];
      end
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      // signed less-than: sign of the difference corrected by overflow
      OP_SLT: begin
        result = {{(DW-1){1'b0}}, sum[DW-1] ^ arith_over};
        over   = arith_over;
        cout   = sum[DW];
      end
      OP_EQ: begin
        result = {{(DW-1){1'b0}}, (a == b)};
        over   = arith_over;
        cout   = sum[DW];
      end
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu4_share_ctrl.sv
// Round-robin sharing controller: grants one of two requesters in IDLE,
// computes on the latched operands in EXEC, and holds a tagged response in RESP.
module alu4_share_ctrl
  import alu4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic [2:0]       req0_op,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [DW-1:0]    rsp_result,
  output logic             rsp_zero,
  output logic             rsp_over,
  output logic             rsp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  state_t        state, state_next;
  logic          rr_ptr;
  logic [1:0]    grant;
  logic [DW-1:0] a_q, b_q;
  logic [2:0]    op_q;
  logic          id_q;
  logic [DW-1:0] alu_result;
  logic          alu_zero, alu_over, alu_cout;

  alu4_core u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero),
    .over   (alu_over),
    .cout   (alu_cout)
  );

  // rr_ptr only breaks ties; a lone requester is always granted
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    unique case (state)
      S_IDLE: begin
        req_ready = grant;
        if (|grant) state_next = S_EXEC;
      end
      S_EXEC: state_next = S_RESP;
      S_RESP: if (rsp_valid && rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_over   <= 1'b0;
      rsp_cout   <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant[1]) begin
            a_q        <= req1_a;
            b_q        <= req1_b;
            op_q       <= req1_op;
            id_q       <= 1'b1;
            grant_cnt1 <= grant_cnt1 + CNT_W'(1);
          end else if (grant[0]) begin
            a_q        <= req0_a;
            b_q        <= req0_b;
            op_q       <= req0_op;
            id_q       <= 1'b0;
            grant_cnt0 <= grant_cnt0 + CNT_W'(1);
          end
        end
        S_EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= id_q;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_over   <= alu_over;
          rsp_cout   <= alu_cout;
        end
        S_RESP: begin
          // the requester just served loses the next tie
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= ~rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu4_share_ctrl.sv
// Self-checking bench for alu4_share_ctrl: vector table plus random ops through a
// response scoreboard, then arbitration, back-pressure and mid-operation reset sequences.
module tb_alu4_share_ctrl;
  import alu4_pkg::*;

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       z;
    logic       o;
    logic       c;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] res;
    logic       z;
    logic       o;
    logic       c;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       rsp_valid, rsp_id, rsp_zero, rsp_over, rsp_cout, busy;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic [7:0] grant_cnt0, grant_cnt1;

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cycle = 0;
  int   n0 = 0;
  int   n1 = 0;
  logic mon_en = 1'b0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  vec_t vecs[13];

  alu4_share_ctrl #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_over   (rsp_over),
    .rsp_cout   (rsp_cout),
    .busy       (busy),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference built from signed/unsigned integer arithmetic, not from the adder form
  function automatic exp_t model(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int sa, sbv, s;
    sa = $signed(a);
    sbv = $signed(b);
    s = sa - sbv;
    e.id = id; e.res = '0; e.o = 1'b0; e.c = 1'b0; e.cyc = 0;
    case (op)
      OP_ADD: begin
        e.res = a + b; s = sa + sbv;
        e.o = (s > 7) || (s < -8);
        e.c = (int'(a) + int'(b)) > 15;
      end
      OP_SUB: begin e.res = a - b; e.o = (s > 7) || (s < -8); e.c = (a >= b); end
      OP_NOT: e.res = ~a;
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_SLT: begin e.res = (sa < sbv) ? 4'd1 : 4'd0; e.o = (s > 7) || (s < -8); e.c = (a >= b); end
      default: begin e.res = (a == b) ? 4'd1 : 4'd0; e.o = (s > 7) || (s < -8); e.c = (a >= b); end
    endcase
    e.z = (e.res == 4'd0);
    return e;
  endfunction

  // drive one request, wait for its grant and log the expected response
  task automatic applyStimulus(input logic id, input logic [2:0] op, input logic [3:0] a,
                               input logic [3:0] b, input exp_t e);
    bit got = 0;
    @(posedge clk); #1;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req_valid = 2'b10; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        e.cyc = cycle;
        sb.push_back(e);
        if (id) n1++; else n0++;
      end
    end
    if (!got) checkOutput("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    sb.delete();
    n0 = 0; n1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (rsp_valid && !prev_valid && sb.size() != 0)
        checkOutput("rsp_latency", cycle, sb[0].cyc + 2);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) checkOutput("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          checkOutput("rsp_id", rsp_id, e.id);
          checkOutput("rsp_result", rsp_result, e.res);
          checkOutput("rsp_flags_zoc", {rsp_zero, rsp_over, rsp_cout}, {e.z, e.o, e.c});
        end
      end
    end
    prev_valid = rsp_valid;
  end

  initial begin
    exp_t e;
    bit seen;
    logic [3:0] ra, rb;
    logic [2:0] rop;
    logic rid;

    vecs[0]  = '{1'b0, OP_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, OP_SUB, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, OP_SLT, 4'b1000, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, OP_SLT, 4'b0001, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, OP_ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, OP_NOT, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_OR,  4'b1100, 4'b0010, 4'b1110, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_XOR, 4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, OP_EQ,  4'b0101, 4'b0101, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, OP_EQ,  4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, OP_SUB, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, OP_SUB, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_result", rsp_result, 0);
    checkOutput("reset_cnts", {grant_cnt0, grant_cnt1}, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    mon_en = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      e = '{vecs[i].id, vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].c, 0};
      applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      rid = 1'($urandom_range(0, 1));
      applyStimulus(rid, rop, ra, rb, model(rid, rop, ra, rb));
    end
    waitDrain();
    checkOutput("grant_cnt0", grant_cnt0, 8'(n0));
    checkOutput("grant_cnt1", grant_cnt1, 8'(n1));

    $display("[TB] round-robin with both requesters");
    resetPulse();
    req0_a = 4'b0001; req0_b = 4'b0010; req0_op = OP_ADD;
    req1_a = 4'b1111; req1_b = 4'b0101; req1_op = OP_XOR;
    req_valid = 2'b11;
    begin
      int g = 0;
      logic side = 1'b0;
      for (int c = 0; c < 60 && g < 4; c++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          checkOutput("rr_grant", req_ready, side ? 2'b10 : 2'b01);
          if (req_ready[1]) e = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, cycle};
          else              e = '{1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, cycle};
          sb.push_back(e);
          side = ~side;
          g++;
        end
      end
      if (g < 4) checkOutput("rr_timeout", g, 4);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitDrain();
    checkOutput("rr_cnt0", grant_cnt0, 2);
    checkOutput("rr_cnt1", grant_cnt1, 2);

    $display("[TB] response back-pressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, OP_ADD, 4'b0111, 4'b0001, '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 0});
    req1_a = 4'b0001; req1_b = 4'b0001; req1_op = OP_ADD;
    req_valid = 2'b10;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) checkOutput("stall_rsp_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall_rsp_valid", rsp_valid, 1);
      checkOutput("stall_result", {rsp_id, rsp_result, rsp_zero, rsp_over, rsp_cout}, {1'b0, 4'b1000, 3'b010});
      checkOutput("stall_req_ready", req_ready, 2'b00);
      checkOutput("stall_busy", busy, 1);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_release_busy", busy, 0);
    checkOutput("stall_release_valid", rsp_valid, 0);
    req_valid = 2'b11;
    #1 checkOutput("rr_after_id0", req_ready, 2'b10);
    req_valid = 2'b00;
    waitDrain();

    $display("[TB] reset during EXEC");
    @(posedge clk); #1;
    req0_a = 4'b0011; req0_b = 4'b0100; req0_op = OP_ADD;
    req_valid = 2'b01;
    @(negedge clk);
    checkOutput("exec_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    checkOutput("exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("exec_rst_valid", rsp_valid, 0);
    checkOutput("exec_rst_busy", busy, 0);
    checkOutput("exec_rst_cnts", {grant_cnt0, grant_cnt1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checkOutput("exec_no_rsp", seen, 0);

    $display("[TB] reset during RESP");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, OP_OR, 4'b0101, 4'b1010, '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 0});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) checkOutput("resp_rsp_timeout", 0, 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("resp_rst_valid", rsp_valid, 0);
    checkOutput("resp_rst_result", {rsp_id, rsp_result}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resp_rst_idle", {busy, rsp_valid}, 0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
